// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and fetches words over a req/ack handshake.
// It presents each word to the decoder, honours stall, and redirects on jumps.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [INSTR_W-1:0] InstrReg,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [ADDR_W-1:0]   pc_target, pc_target_n;
  logic [INSTR_W-1:0]  instr_n;
  logic [ADDR_W-1:0]   pc_out_n;
  logic                valid_n;
  logic                req_n;

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and datapath updates; a held unconsumed word blocks any new ack.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pc_target_n = pc_target;
    instr_n     = InstrReg;
    pc_out_n    = pc_out;
    valid_n     = instr_valid;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (jump_en) begin
          valid_n = 1'b0;
          if (imem_ack) begin
            pc_n = jump_addr;
          end else begin
            pc_target_n = jump_addr;
            state_n     = DRAIN;
          end
        end else if (instr_valid && stall) begin
          state_n = HOLD;
        end else if (imem_ack) begin
          instr_n  = imem_data;
          pc_out_n = pc;
          valid_n  = 1'b1;
          pc_n     = ADDR_W'(pc + 1'b1);
        end else if (instr_valid) begin
          valid_n = 1'b0;
        end
      end
      DRAIN: begin
        if (jump_en) pc_target_n = jump_addr;
        if (imem_ack) begin
          pc_n    = jump_en ? jump_addr : pc_target;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (jump_en) begin
          pc_n    = jump_addr;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (!stall) begin
          valid_n = 1'b0;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
    req_n = (state_n == FETCH) || (state_n == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      pc_target   <= RESET_PC;
      imem_req    <= 1'b0;
      InstrReg    <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
    end else begin
      pc          <= pc_n;
      pc_target   <= pc_target_n;
      imem_req    <= req_n;
      InstrReg    <= instr_n;
      instr_valid <= valid_n;
      pc_out      <= pc_out_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall hold, jumps, PC wrap, reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall;
  logic        jump_en;
  logic [8:0]  jump_addr;
  logic [15:0] InstrReg;
  logic        instr_valid;
  logic [8:0]  pc_out;

  logic        auto_mem;
  logic        man_ack;
  logic [15:0] man_data;
  int          errors = 0;
  int          checks = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .stall(stall),
    .jump_en(jump_en), .jump_addr(jump_addr), .InstrReg(InstrReg),
    .instr_valid(instr_valid), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [8:0] a);
    return (a == 9'd5) ? 16'h1234 : (16'hA000 | {7'd0, a});
  endfunction

  // Zero-wait memory in auto mode, otherwise the bench drives ack/data by hand.
  assign imem_ack  = auto_mem ? imem_req : man_ack;
  assign imem_data = auto_mem ? word_at(imem_addr) : man_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_instr"}, 32'(InstrReg), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_pcout"}, 32'(pc_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1; auto_mem = 1'b1; man_ack = 1'b0; man_data = 16'h0;
    stall = 1'b0; jump_en = 1'b0; jump_addr = 9'h0;
    step(); step();
    chk_reset("reset");

    // Streaming with zero-wait memory
    rst = 1'b0;
    step();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", 32'(imem_addr), 32'd0);
    chk("t1_valid0", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_addr", 32'(imem_addr), 32'(k + 1));
      chk("t1_instr", 32'(InstrReg), (k == 5) ? 32'h1234 : 32'(16'hA000 + k));
      chk("t1_pcout", 32'(pc_out), 32'(k));
      chk("t1_valid", 32'(instr_valid), 32'd1);
    end

    // Stall holds the word at pc_out 5
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_req", 32'(imem_req), 32'd0);
      chk("t2_instr", 32'(InstrReg), 32'h1234);
      chk("t2_pcout", 32'(pc_out), 32'd5);
      chk("t2_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    chk("t2_req_resume", 32'(imem_req), 32'd1);
    chk("t2_addr_resume", 32'(imem_addr), 32'd6);
    chk("t2_valid_consumed", 32'(instr_valid), 32'd0);
    step();
    chk("t2_instr6", 32'(InstrReg), 32'hA006);
    chk("t2_pcout6", 32'(pc_out), 32'd6);
    chk("t2_addr7", 32'(imem_addr), 32'd7);

    // Jump during an outstanding request, ack two cycles late
    auto_mem = 1'b0; jump_en = 1'b1; jump_addr = 9'h0A0;
    step();
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr_old", 32'(imem_addr), 32'd7);
    jump_en = 1'b0;
    step();
    chk("t3_addr_wait", 32'(imem_addr), 32'd7);
    man_ack = 1'b1; man_data = 16'hBEEF;
    step();
    chk("t3_addr_new", 32'(imem_addr), 32'h0A0);
    chk("t3_valid_drop", 32'(instr_valid), 32'd0);
    chk("t3_req_new", 32'(imem_req), 32'd1);

    // Jump coincident with ack, then two jumps while draining
    man_data = 16'hDEAD; jump_en = 1'b1; jump_addr = 9'h150;
    step();
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_addr", 32'(imem_addr), 32'h150);
    man_ack = 1'b0; jump_addr = 9'h010;
    step();
    jump_addr = 9'h020;
    step();
    chk("t4_drain_addr", 32'(imem_addr), 32'h150);
    chk("t4_drain_req", 32'(imem_req), 32'd1);
    jump_en = 1'b0; man_ack = 1'b1;
    step();
    chk("t4_last_jump", 32'(imem_addr), 32'h020);
    chk("t4_valid_drop", 32'(instr_valid), 32'd0);
    man_data = 16'h4321;
    step();
    chk("t4_instr", 32'(InstrReg), 32'h4321);
    chk("t4_pcout", 32'(pc_out), 32'h020);
    chk("t4_valid", 32'(instr_valid), 32'd1);
    chk("t4_addr_next", 32'(imem_addr), 32'h021);

    // PC wraps from 0x1FF to 0x000
    man_ack = 1'b0; jump_en = 1'b1; jump_addr = 9'h1FF;
    step();
    jump_en = 1'b0; man_ack = 1'b1;
    step();
    chk("t5_addr_1ff", 32'(imem_addr), 32'h1FF);
    man_data = 16'h5555;
    step();
    chk("t5_instr", 32'(InstrReg), 32'h5555);
    chk("t5_pcout", 32'(pc_out), 32'h1FF);
    chk("t5_wrap", 32'(imem_addr), 32'h000);

    // Reset mid-request, ack during reset ignored
    rst = 1'b1;
    #1;
    chk_reset("t6_midreq");
    step();
    chk("t6_ack_in_rst", 32'(instr_valid), 32'd0);
    man_ack = 1'b0; auto_mem = 1'b1; rst = 1'b0;
    step();
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    step();
    stall = 1'b1;
    step();
    chk("t6_hold_req", 32'(imem_req), 32'd0);
    chk("t6_hold_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset("t6_midhold");
    stall = 1'b0; rst = 1'b0;
    step();
    chk("t6_refetch_addr", 32'(imem_addr), 32'd0);
    step();
    chk("t6_refetch_instr", 32'(InstrReg), 32'hA000);
    chk("t6_refetch_pcout", 32'(pc_out), 32'd0);
    chk("t6_refetch_valid", 32'(instr_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
